// File: rtl/fault_campaign_pkg.sv
// Shared types and default sizing for the fault-injection campaign controller.
// Holds the FSM state enum, the default DATA_W/LOC_W/NUM_LOCS/LATENCY values and the weight width.
package fault_campaign_pkg;

   localparam int DATA_W_DEF   = 128;
   localparam int LOC_W_DEF    = 7;
   localparam int NUM_LOCS_DEF = 128;
   localparam int LATENCY_DEF  = 22;
   localparam int WEIGHT_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      GOLD_WAIT,
      FAULT_WAIT,
      EMIT,
      DONE
   } state_e;

endpackage

// File: rtl/fault_campaign_ctrl_popcount.sv
// fc_popcount: combinational population count of a DATA_W-bit word.
// Ports: data_i (DATA_W) in, count_o (WEIGHT_W) out.
module fc_popcount
   import fault_campaign_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0]   data_i,
   output logic [WEIGHT_W-1:0] count_o
);

   logic [WEIGHT_W-1:0] acc;

   // Written as a flat sum; synthesis balances it into an adder tree.
   always_comb begin
      acc = '0;
      for (int i = 0; i < DATA_W; i++) begin
         acc = acc + WEIGHT_W'(data_i[i]);
      end
      count_o = acc;
   end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: sweeps fault locations, runs golden+faulted encryptions, streams diff records.
// Ports: CLK_50, RST (sync, active-high), start/busy/done, fault_en/fault_loc to the core,
// core_out from the core, rec_valid/rec_ready handshake with rec_loc/rec_golden/rec_diff/rec_weight.
// Build option: FAULT_CAMPAIGN_SKIP_ZERO_EN suppresses records whose diff is all-zero.
module fault_campaign_ctrl
   import fault_campaign_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LOC_W    = LOC_W_DEF,
   parameter int NUM_LOCS = NUM_LOCS_DEF,
   parameter int LATENCY  = LATENCY_DEF
) (
   input  logic                CLK_50,
   input  logic                RST,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                fault_en,
   output logic [LOC_W-1:0]    fault_loc,
   input  logic [DATA_W-1:0]   core_out,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [LOC_W-1:0]    rec_loc,
   output logic [DATA_W-1:0]   rec_golden,
   output logic [DATA_W-1:0]   rec_diff,
   output logic [WEIGHT_W-1:0] rec_weight
);

   localparam int CNT_W = $clog2(LATENCY);
   localparam int LCW   = LOC_W + 1;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   // One spare bit so the last location never wraps when NUM_LOCS = 2^LOC_W.
   logic [LCW-1:0]       loc_q, loc_d;
   logic [DATA_W-1:0]    golden_q, golden_d;
   logic [DATA_W-1:0]    diff_q, diff_d;
   logic [WEIGHT_W-1:0]  weight_q, weight_d;

   logic [DATA_W-1:0]    diff_now;
   logic [WEIGHT_W-1:0]  weight_now;
   logic                 cnt_last;
   logic                 loc_last;

   assign diff_now = golden_q ^ core_out;
   assign cnt_last = (cnt_q == CNT_W'(LATENCY - 1));
   assign loc_last = (loc_q == LCW'(NUM_LOCS - 1));

   fc_popcount #(
      .DATA_W (DATA_W)
   ) u_popcount (
      .data_i  (diff_now),
      .count_o (weight_now)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      loc_d    = loc_q;
      golden_d = golden_q;
      diff_d   = diff_q;
      weight_d = weight_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = GOLD_WAIT;
               loc_d   = '0;
               cnt_d   = '0;
            end
         end
         GOLD_WAIT: begin
            if (cnt_last) begin
               golden_d = core_out;
               cnt_d    = '0;
               state_d  = FAULT_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FAULT_WAIT: begin
            if (cnt_last) begin
               diff_d   = diff_now;
               weight_d = weight_now;
               cnt_d    = '0;
`ifdef FAULT_CAMPAIGN_SKIP_ZERO_EN
               // Ineffective fault: move on without emitting a record.
               if (diff_now == '0) begin
                  if (loc_last) begin
                     state_d = DONE;
                  end else begin
                     loc_d   = loc_q + LCW'(1);
                     state_d = GOLD_WAIT;
                  end
               end else begin
                  state_d = EMIT;
               end
`else
               state_d = EMIT;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         EMIT: begin
            if (rec_ready) begin
               if (loc_last) begin
                  state_d = DONE;
               end else begin
                  loc_d   = loc_q + LCW'(1);
                  state_d = GOLD_WAIT;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            loc_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         loc_q    <= '0;
         golden_q <= '0;
         diff_q   <= '0;
         weight_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         loc_q    <= loc_d;
         golden_q <= golden_d;
         diff_q   <= diff_d;
         weight_q <= weight_d;
      end
   end

   assign busy       = (state_q == GOLD_WAIT) || (state_q == FAULT_WAIT) ||
                       (state_q == EMIT);
   assign done       = (state_q == DONE);
   assign fault_en   = (state_q == FAULT_WAIT);
   assign fault_loc  = loc_q[LOC_W-1:0];
   assign rec_valid  = (state_q == EMIT);
   assign rec_loc    = loc_q[LOC_W-1:0];
   assign rec_golden = golden_q;
   assign rec_diff   = diff_q;
   assign rec_weight = weight_q;

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Directed testbench for fault_campaign_ctrl with a LATENCY-delayed cipher core model.
// Covers reset, full sweep timing, backpressure, start-while-busy, mid-run reset and zero-diff locations.
module tb_fault_campaign_ctrl;
   import fault_campaign_pkg::*;

   localparam int LAT = 22;
   localparam int DW  = 128;
   localparam int LW  = 7;
   localparam int NL  = 128;
   localparam logic [DW-1:0] C = 128'h3925841d02dc09fbdc118597196a0b32;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                rec_ready = 1'b1;
   logic                busy, done, fault_en, rec_valid;
   logic [LW-1:0]       fault_loc, rec_loc;
   logic [DW-1:0]       core_out, rec_golden, rec_diff;
   logic [WEIGHT_W-1:0] rec_weight;

   fault_campaign_ctrl dut (
      .CLK_50     (clk),
      .RST        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .fault_en   (fault_en),
      .fault_loc  (fault_loc),
      .core_out   (core_out),
      .rec_valid  (rec_valid),
      .rec_ready  (rec_ready),
      .rec_loc    (rec_loc),
      .rec_golden (rec_golden),
      .rec_diff   (rec_diff),
      .rec_weight (rec_weight)
   );

   always #5 clk = ~clk;

   // Core model: output reflects controls seen LAT cycles ago.
   logic          pipe_en  [LAT-1];
   logic [LW-1:0] pipe_loc [LAT-1];
   bit            skip_even = 1'b0;

   always @(posedge clk) begin
      pipe_en[0]  <= fault_en;
      pipe_loc[0] <= fault_loc;
      for (int i = 1; i < LAT - 1; i++) begin
         pipe_en[i]  <= pipe_en[i-1];
         pipe_loc[i] <= pipe_loc[i-1];
      end
   end

   always_comb begin
      core_out = C;
      if (pipe_en[LAT-2] === 1'b1 &&
          !(skip_even && pipe_loc[LAT-2][0] == 1'b0))
         core_out = C ^ (128'd1 << pipe_loc[LAT-2]);
   end

   int hs_cnt = 0;
   always @(posedge clk)
      if (rec_valid === 1'b1 && rec_ready === 1'b1) hs_cnt <= hs_cnt + 1;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic start_campaign();
      start = 1'b1;
      cyc   = 0;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_rec(input string tag);
      int n = 0;
      while (!(rec_valid === 1'b1 || done === 1'b1) && n < 300) begin
         tick();
         n++;
      end
      chk(tag, rec_valid, 1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      chk(tag, done, 1);
   endtask

   logic [DW-1:0]       snap_g, snap_d, exp_d;
   logic [WEIGHT_W-1:0] snap_w;
   int                  ndone, nval, hs0, exp_recs;

   initial begin
      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fault_en", fault_en, 0);
      chk("rst_rec_valid", rec_valid, 0);
      chk("rst_fault_loc", fault_loc, 0);
      chk("rst_rec_loc", rec_loc, 0);
      chk("rst_rec_golden", rec_golden, 0);
      chk("rst_rec_diff", rec_diff, 0);
      chk("rst_rec_weight", rec_weight, 0);

      // Full sweep, rec_ready held high
      start_campaign();
      chk("sweep_busy", busy, 1);
      chk("sweep_gold_en", fault_en, 0);
      while (cyc < LAT) tick();
      chk("sweep_gold_last_en", fault_en, 0);
      tick();
      chk("sweep_fault_en", fault_en, 1);
      chk("sweep_fault_loc", fault_loc, 0);
      for (int loc = 0; loc < NL; loc++) begin
         wait_rec("sweep_rec_timeout");
         if (loc == 0) chk("sweep_first_valid_cyc", cyc, 2 * LAT + 1);
         chk("sweep_rec_loc", rec_loc, loc);
         chk("sweep_rec_golden", rec_golden, C);
         chk("sweep_rec_diff", rec_diff, 128'd1 << loc);
         chk("sweep_rec_weight", rec_weight, 1);
         tick();
      end
      wait_done("sweep_done_timeout");
      chk("sweep_done_cyc", cyc, NL * (2 * LAT + 1) + 1);
      chk("sweep_done_busy", busy, 0);
      tick();
      chk("sweep_done_pulse", done, 0);
      chk("sweep_idle_en", fault_en, 0);

      // Backpressure on loc 5, start pulsed during loc 3
      start_campaign();
      for (int loc = 0; loc < NL; loc++) begin
         if (loc == 3) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         wait_rec("bp_rec_timeout");
         chk("bp_rec_loc", rec_loc, loc);
         chk("bp_rec_diff", rec_diff, 128'd1 << loc);
         if (loc == 5) begin
            rec_ready = 1'b0;
            snap_g = rec_golden;
            snap_d = rec_diff;
            snap_w = rec_weight;
            for (int i = 1; i <= 10; i++) begin
               tick();
               chk("bp_stall_valid", rec_valid, 1);
               chk("bp_stall_loc", rec_loc, 5);
               chk("bp_stall_golden", rec_golden, snap_g);
               chk("bp_stall_diff", rec_diff, snap_d);
               chk("bp_stall_weight", rec_weight, snap_w);
               chk("bp_stall_fault_en", fault_en, 0);
               chk("bp_stall_fault_loc", fault_loc, 5);
            end
            rec_ready = 1'b1;
            tick();
            chk("bp_next_loc", fault_loc, 6);
            chk("bp_next_valid", rec_valid, 0);
            chk("bp_next_busy", busy, 1);
         end else begin
            tick();
         end
      end
      wait_done("bp_done_timeout");
      ndone = 0;
      repeat (60) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      chk("bp_extra_done", ndone, 0);
      chk("bp_idle_busy", busy, 0);

      // Reset during FAULT_WAIT of loc 40
      start_campaign();
      for (int loc = 0; loc < 40; loc++) begin
         wait_rec("rr_rec_timeout");
         tick();
      end
      begin
         int n = 0;
         while (fault_en !== 1'b1 && n < 100) begin
            tick();
            n++;
         end
      end
      chk("rr_in_fault", fault_en, 1);
      chk("rr_in_fault_loc", fault_loc, 40);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("rr_fault_en", fault_en, 0);
      chk("rr_busy", busy, 0);
      chk("rr_rec_valid", rec_valid, 0);
      chk("rr_done", done, 0);
      chk("rr_fault_loc", fault_loc, 0);
      rst = 1'b0;
      ndone = 0;
      nval  = 0;
      repeat (30) begin
         tick();
         if (done === 1'b1) ndone++;
         if (rec_valid === 1'b1) nval++;
      end
      chk("rr_no_done", ndone, 0);
      chk("rr_no_rec", nval, 0);
      start_campaign();
      wait_rec("rr_restart_timeout");
      chk("rr_restart_cyc", cyc, 2 * LAT + 1);
      chk("rr_restart_loc", rec_loc, 0);
      chk("rr_restart_diff", rec_diff, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Even locations produce no fault
      skip_even = 1'b1;
      hs0 = hs_cnt;
`ifdef FAULT_CAMPAIGN_SKIP_ZERO_EN
      exp_recs = NL / 2;
`else
      exp_recs = NL;
`endif
      start_campaign();
      for (int loc = 0; loc < NL; loc++) begin
`ifdef FAULT_CAMPAIGN_SKIP_ZERO_EN
         if (loc % 2 == 0) continue;
`endif
         wait_rec("sz_rec_timeout");
         chk("sz_rec_loc", rec_loc, loc);
         exp_d = (loc % 2 == 0) ? '0 : (128'd1 << loc);
         chk("sz_rec_diff", rec_diff, exp_d);
         chk("sz_rec_weight", rec_weight, (loc % 2 == 0) ? 0 : 1);
         tick();
      end
      wait_done("sz_done_timeout");
      tick();
      chk("sz_rec_count", hs_cnt - hs0, exp_recs);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fault_campaign_ctrl.md
# fault_campaign_ctrl

On-chip fault-injection campaign controller that replaces the host-driven stimulus on the switch inputs of the cipher core. It sweeps every fault location, runs a golden and a faulted encryption for each, captures the core output after a fixed latency, and streams records over a valid/ready port: location, golden ciphertext, fault difference and difference weight. It sits between the core's `SW[9]`/`SW[6:0]` controls and its `out` bus on one side and a record sink (UART/FIFO) on the other.

## Interface
- `DATA_W`, 128: core output width.
- `LOC_W`, 7: fault-location width.
- `NUM_LOCS`, 128: number of locations swept, 0..NUM_LOCS-1; must be ≤ 2^LOC_W.
- `LATENCY`, 22: cycles from a control change until `core_out` is settled; must be ≥ 2.

- `CLK_50` in 1: single clock.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: campaign start request; sampled only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until `done`.
- `done` out 1: one-cycle pulse at campaign end.
- `fault_en` out 1: drives core `SW[9]`.
- `fault_loc` out LOC_W: drives core `SW[6:0]`.
- `core_out` in DATA_W: core ciphertext output.
- `rec_valid` out 1: record available.
- `rec_ready` in 1: sink accepts record.
- `rec_loc` out LOC_W: location of the record.
- `rec_golden` out DATA_W: fault-free ciphertext.
- `rec_diff` out DATA_W: golden XOR faulted ciphertext.
- `rec_weight` out 8: popcount of `rec_diff` (0..128).

## Operation
- States: IDLE, GOLD_WAIT, FAULT_WAIT, EMIT, DONE.
- IDLE: `busy`=0 and `fault_en`=0. `start`=1 → GOLD_WAIT, loc=0, wait counter=0.
- GOLD_WAIT: `fault_en`=0 and `fault_loc`=loc. The counter counts 0..LATENCY-1. On the cycle where counter==LATENCY-1, `core_out` is registered into the golden register, the counter clears, and the FSM → FAULT_WAIT.
- FAULT_WAIT: `fault_en`=1 and `fault_loc`=loc. On the same counter rule, `golden ^ core_out` is registered into diff, the popcount is registered into weight, and the FSM → EMIT.
- EMIT: `rec_valid`=1. The `rec_*` fields stay stable until `rec_valid && rec_ready`.
- On handshake:
  - if loc==NUM_LOCS-1 → DONE;
  - else loc+1 → GOLD_WAIT.
- DONE: `done`=1 for one cycle → IDLE. `busy` drops in this same cycle.
- `start` is ignored outside IDLE.
- `rec_ready` is ignored outside EMIT.
- `fault_en` returns to 0 in EMIT, DONE and IDLE, so the core is never left faulted between runs.
- The loc counter is LOC_W+1 bits wide internally. This prevents wrap when NUM_LOCS = 2^LOC_W.

## Timing
- Reset values: state IDLE; `busy`, `done`, `fault_en`, `rec_valid` = 0; `fault_loc`, `rec_loc`, `rec_golden`, `rec_diff`, `rec_weight`, counters = 0.
- `RST` asserted mid-campaign: next cycle is IDLE with reset values, including `fault_en`=0. No `done` pulse and no partial record.
- Start accepted at edge t:
  - GOLD_WAIT covers cycles t+1..t+LATENCY;
  - FAULT_WAIT covers t+LATENCY+1..t+2·LATENCY;
  - `rec_valid` rises at t+2·LATENCY+1.
- With `rec_ready` held high, each location costs 2·LATENCY+1 cycles. A full default campaign is 128·45 = 5760 cycles; `done` pulses in the cycle after the last handshake.
- Backpressure: each cycle `rec_ready`=0 adds one cycle. `fault_loc` and `fault_en` do not change during the stall.
- The sampled `core_out` always reflects controls that have been held for exactly LATENCY cycles.

## Configuration
- `FAULT_CAMPAIGN_SKIP_ZERO_EN`:
  - When defined, a location whose diff is all-zero (ineffective fault) produces no record. FAULT_WAIT goes straight to the next GOLD_WAIT, or to DONE for the last location. A skipped location costs 2·LATENCY cycles.
  - When undefined, every location emits exactly one record, including ones with `rec_weight`=0.

## Structure
- Package `fault_campaign_pkg` holds:
  - the state enum;
  - default constants for DATA_W, LOC_W, NUM_LOCS and LATENCY;
  - the weight width, 8.
- Sub-module `fc_popcount`: combinational DATA_W-bit popcount (adder tree) feeding the weight register. It is instantiated once.

## Test plan
- **Core model:** all scenarios use a bench core model that outputs `C=128'h3925841d02dc09fbdc118597196a0b32` when `fault_en`=0 and `C ^ (1<<fault_loc)` when `fault_en`=1, each valid LATENCY cycles after a control change.
- **Full sweep with `rec_ready`=1:**
  - 128 records are emitted, with `rec_loc` 0..127 in order;
  - `rec_golden`=C, `rec_diff`=1<<loc and `rec_weight`=1 on every record;
  - the first `rec_valid` appears at t+45 and `done` appears at t+5761.
- **Backpressure:** `rec_ready` is low for 10 cycles on loc 5. The record is held stable, `fault_en`=0 throughout the stall, and loc 6 starts the cycle after the handshake.
- **Reset mid-FAULT_WAIT at loc 40:** the next cycle has `fault_en`=0, `busy`=0 and `rec_valid`=0, with no `done`. A new `start` resumes at loc 0.
- **Skip-zero:** the model returns C unfaulted for even locs.
  - Without the macro: 128 records, even ones with weight 0.
  - With `FAULT_CAMPAIGN_SKIP_ZERO_EN`: exactly 64 records, for odd locs only.
- **Start while busy:** `start` is pulsed at loc 3 and is ignored. The sweep completes normally with a single `done`.
